// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART RX controller: rising-edge capture of
// data_valid, show-ahead valid/ready read port. Optional almost_full via RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH  = DEPTH - 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_err,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Each entry carries the error tag in its MSB.
    logic [DATA_WIDTH:0]   mem [DEPTH];

    logic                  wr_valid_q_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  overflow_reg, overflow_next;

    logic wr_stb;
    logic rd_hs;
    logic wr_accept;
    logic wr_drop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == FULL_CNT);
    assign count    = count_reg;
    assign rd_valid = ~empty;
    assign overflow = overflow_reg;

    assign wr_stb    = wr_valid & ~wr_valid_q_reg;
    assign rd_hs     = rd_valid & rd_ready;
    // At full, a same-cycle pop frees the slot the write lands in.
    assign wr_accept = wr_stb & (~full | rd_hs);
    assign wr_drop   = wr_stb & full & ~rd_hs;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);
        end
        if (rd_hs) begin
            rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(1);
        end
        if (wr_accept && !rd_hs) begin
            count_next = count_reg + (ADDR_WIDTH + 1)'(1);
        end else if (rd_hs && !wr_accept) begin
            count_next = count_reg - (ADDR_WIDTH + 1)'(1);
        end
        if (ovf_clr) begin
            overflow_next = 1'b0;
        end
        if (wr_drop) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Starts high so a level already asserted at reset release is not a write.
            wr_valid_q_reg <= 1'b1;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            wr_valid_q_reg <= wr_valid;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= {wr_err, wr_data};
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_reg][DATA_WIDTH-1:0];
    assign rd_err  = empty ? 1'b0 : mem[rd_ptr_reg][DATA_WIDTH];

`ifdef RX_FIFO_ALMOST_FULL_EN
    assign almost_full = (count_reg >= (ADDR_WIDTH + 1)'(AF_THRESH));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed writes push expected entries,
// a negedge monitor pops and compares on every read handshake.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       ovf_clr;
`ifdef RX_FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    uart_rx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef RX_FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", {23'd0, rd_err, rd_data}, 32'h1ff);
            end else begin
                e = exp_q.pop_front();
                check("read_entry", {23'd0, rd_err, rd_data}, {23'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pulse(input logic [7:0] d, input logic e, input bit expect_store);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_err   = e;
        if (expect_store) exp_q.push_back({e, d});
        tick();
        wr_valid = 1'b0;
        tick();
    endtask

    task automatic drain();
        bit done = 0;
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (empty) begin
                done = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b0;
        tick();
        check("drain_done", {31'd0, done}, 32'd1);
        check("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        wr_err   = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;

        // T1: reset release with wr_valid high must not write
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) tick();
        check("t1_empty", {31'd0, empty}, 32'd1);
        check("t1_count", {28'd0, count}, 32'd0);
        check("t1_overflow", {31'd0, overflow}, 32'd0);
        check("t1_rd_data", {24'd0, rd_data}, 32'd0);
        wr_valid = 1'b0;
        tick();

        // T2: single write, show-ahead, pop
        write_pulse(8'hA5, 1'b0, 1);
        check("t2_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("t2_rd_data", {24'd0, rd_data}, 32'hA5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t2_empty", {31'd0, empty}, 32'd1);
        check("t2_rd_data_zero", {24'd0, rd_data}, 32'd0);
        check("t2_sb", exp_q.size(), 32'd0);

        // T3: level held 20 cycles -> one entry
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        wr_err   = 1'b0;
        exp_q.push_back({1'b0, 8'h3C});
        repeat (20) tick();
        wr_valid = 1'b0;
        tick();
        check("t3_count", {28'd0, count}, 32'd1);
        drain();

        // T4: fill plus one -> overflow, 08 dropped
        for (int i = 0; i < 9; i++) write_pulse(8'(i), 1'b0, i < 8);
        check("t4_full", {31'd0, full}, 32'd1);
        check("t4_count", {28'd0, count}, 32'd8);
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        drain();

        // T5: write and read together while full
        for (int i = 0; i < 8; i++) write_pulse(8'h10 + 8'(i), 1'b0, 1);
        check("t5_full", {31'd0, full}, 32'd1);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        wr_err   = 1'b0;
        rd_ready = 1'b1;
        exp_q.push_back({1'b0, 8'hEE});
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        check("t5_count", {28'd0, count}, 32'd8);
        check("t5_overflow", {31'd0, overflow}, 32'd0);
        drain();

        // T6: error tag ordering
        write_pulse(8'h55, 1'b1, 1);
        write_pulse(8'h66, 1'b0, 1);
        check("t6_head_err", {31'd0, rd_err}, 32'd1);
        drain();

`ifdef RX_FIFO_ALMOST_FULL_EN
        for (int i = 0; i < 5; i++) write_pulse(8'h70 + 8'(i), 1'b0, 1);
        check("t6_af_at5", {31'd0, almost_full}, 32'd0);
        write_pulse(8'h75, 1'b0, 1);
        check("t6_af_at6", {31'd0, almost_full}, 32'd1);
        drain();
`endif

        // Reset mid-operation discards contents at once
        write_pulse(8'h81, 1'b0, 1);
        write_pulse(8'h82, 1'b0, 1);
        write_pulse(8'h83, 1'b0, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_empty", {31'd0, empty}, 32'd1);
        check("rst_mid_count", {28'd0, count}, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_rd_valid", {31'd0, rd_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
